palette_ram_ctrl: RTL
=====================

# palette_ram_ctrl

Controller and arbiter for the 32-entry PPU palette RAM ($3F00–$3F1F). It shares a single-port 32×6 storage array between the pixel renderer, which reads once per pixel, and the CPU $2007 data port, which reads and writes. It applies NES palette mirroring and the optional grayscale mask, and delivers an 8-bit color code to the downstream `palette_look_up` RGB decoder.

## Interface
Parameters:
- `STARVE_MAX`, default 8: number of consecutive denied CPU cycles before the CPU is forced a slot.

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: asynchronous, active-high.
- `pix_req` in 1: renderer requests a palette read this cycle.
- `pix_idx` in 5: palette index from the BG/sprite priority mux.
- `grayscale` in 1: PPUMASK bit 0.
- `pix_valid` out 1: `color_code` is valid.
- `color_code` out 8: `{2'b00, entry[5:0]}` to `palette_look_up`.
- `cpu_req` in 1: CPU access request, level, held until ack.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 5: palette address, bits [4:0] of $3F00–$3F1F.
- `cpu_wdata` in 6: write data.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 6: read data, valid while `cpu_ack` = 1.

## Operation
- Mirroring applies to both ports. Addresses 5'h10, 5'h14, 5'h18 and 5'h1C map to 5'h00, 5'h04, 5'h08 and 5'h0C. All other addresses map to themselves.
- One RAM access per cycle. Grant rules:
  - The renderer wins when `pix_req` = 1 and `starve_cnt` < `STARVE_MAX`.
  - Otherwise, the CPU wins if a CPU request is pending.
- `starve_cnt`:
  - Increments each cycle a pending CPU request is denied.
  - Clears on a CPU grant, and whenever no CPU request is pending.
  - Saturates at `STARVE_MAX`.
- Forced CPU slot while `pix_req` = 1: the render pipeline replays the previous `color_code` with `pix_valid` = 1, so pixel cadence is preserved.
- CPU FSM:
  - `C_IDLE`: when `cpu_req` = 1 and the CPU is granted, perform the access, go to `C_ACK`. When `cpu_req` = 1 and the CPU is denied, stay in `C_IDLE` (request pending).
  - `C_ACK`: `cpu_ack` = 1, `cpu_rdata` = read data (0 for writes). Return to `C_IDLE` unconditionally.
  - `cpu_req` is ignored during `C_ACK`. The requester drops `cpu_req` in the `C_ACK` cycle.
- Write data is stored as 6 bits. `cpu_wdata[5:0]` is written in the grant cycle.
- Grayscale: output entry = `entry & 6'h30` when enabled (see Configuration).

## Timing
- Render latency is 2 cycles:
  - Cycle N: `pix_req`/`pix_idx` sampled.
  - Cycle N+1: RAM data registered.
  - Cycle N+2: `color_code`/`pix_valid` registered output.
- Pipeline stalls are never introduced. `pix_valid` at N+2 equals `pix_req` at N.
- CPU latency: `cpu_ack` asserts the cycle after the grant. An uncontended access gives ack 1 cycle after `cpu_req` rises. Worst case is `STARVE_MAX`+1 cycles.
- Write at grant cycle N is visible to a render or CPU read granted at N+1. No read-during-write forwarding is required, because there is only one access per cycle.
- Reset values (asynchronous):
  - `color_code` = 8'h00, `pix_valid` = 0, `cpu_ack` = 0, `cpu_rdata` = 0.
  - FSM = `C_IDLE`, `starve_cnt` = 0.
  - All 32 RAM entries = 6'h00.
- Reset mid-access: any in-flight write is dropped, pipeline contents are discarded, and no ack is issued after reset release.
- Simultaneous `pix_req` and new `cpu_req` with `starve_cnt` = 0: the renderer wins and the CPU waits.

## Configuration
- `PAL_GRAYSCALE_EN` defined: the `grayscale` input is honored and masks output with 6'h30. `cpu_rdata` is never masked.
- Not defined: the `grayscale` port exists but is ignored, and the output is the raw entry.

## Structure
- Package `palette_pkg` holds:
  - `PAL_ADDR_W` = 5 and `PAL_DATA_W` = 6.
  - The `cpu_state_t` enum (`C_IDLE`, `C_ACK`).
  - Function `pal_mirror(addr)`.
  - Constant `GRAY_MASK` = 6'h30.
- Sub-module `palette_ram`: 32×6 register array with asynchronous reset, one read/write port, and a registered read.
- The arbiter, FSM, starvation counter and output stage live in `palette_ram_ctrl`.

## Test plan
- CPU writes 6'h2A to 5'h03, then the renderer reads idx 5'h03 → ack 1 cycle after req; `color_code` = 8'h2A with `pix_valid` 2 cycles after `pix_req`.
- CPU writes 6'h16 to 5'h10, then CPU reads 5'h00 → `cpu_rdata` = 6'h16. The renderer reading idx 5'h1C returns the 5'h0C entry.
- `pix_req` held high continuously, with CPU read pending and `STARVE_MAX` = 8 → ack 9 cycles after req. `pix_valid` stays 1 throughout, and the forced-slot pixel repeats the prior `color_code`.
- Entry 5'h05 = 6'h27, `grayscale` = 1 → `color_code` = 8'h20 with the macro defined, and 8'h27 without it.
- Same-cycle `pix_req` and `cpu_req` with `starve_cnt` = 0 → render data returned first; CPU ack 1 cycle after `pix_req` drops.
- Reset asserted during `C_ACK` after a write of 6'h3F to 5'h01 → all outputs go to 0 immediately; a subsequent read of 5'h01 returns 6'h00.

Source files
------------

// File: rtl/palette_pkg.sv
// Shared types and helpers for the PPU palette RAM controller: geometry,
// CPU handshake states, $3F1x mirroring and the grayscale mask.
package palette_pkg;

    localparam int PAL_ADDR_W = 5;
    localparam int PAL_DATA_W = 6;
    localparam int PAL_DEPTH  = 1 << PAL_ADDR_W;

    localparam logic [PAL_DATA_W-1:0] GRAY_MASK = 6'h30;

    typedef enum logic {
        C_IDLE = 1'b0,
        C_ACK  = 1'b1
    } cpu_state_t;

    // Sprite backdrop slots $3F10/$14/$18/$1C alias the background ones.
    function automatic logic [PAL_ADDR_W-1:0] pal_mirror(input logic [PAL_ADDR_W-1:0] addr);
        if (addr[4] && (addr[1:0] == 2'b00)) begin
            return {1'b0, addr[3:0]};
        end
        return addr;
    endfunction

endpackage

// File: rtl/palette_ram.sv
// 32x6 palette storage: one shared read/write port, registered read data,
// every entry cleared by the asynchronous reset.
module palette_ram
    import palette_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [PAL_ADDR_W-1:0] addr,
    input  logic [PAL_DATA_W-1:0] wdata,
    output logic [PAL_DATA_W-1:0] rdata
);

    logic [PAL_DATA_W-1:0] mem [PAL_DEPTH];

    // Read returns the pre-write contents; the arbiter never reads and
    // writes the same slot for two different masters in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PAL_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/palette_ram_ctrl.sv
// Palette RAM arbiter between the pixel renderer and the CPU $2007 port.
// Define PAL_GRAYSCALE_EN to honour the grayscale input on the render output.
module palette_ram_ctrl
    import palette_pkg::*;
#(
    parameter int STARVE_MAX = 8
)
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  pix_req,
    input  logic [PAL_ADDR_W-1:0] pix_idx,
    input  logic                  grayscale,
    output logic                  pix_valid,
    output logic [7:0]            color_code,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [PAL_ADDR_W-1:0] cpu_addr,
    input  logic [PAL_DATA_W-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [PAL_DATA_W-1:0] cpu_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    cpu_state_t            state;
    cpu_state_t            state_next;
    logic [CNT_W-1:0]      starve_cnt;
    logic                  cpu_pend;
    logic                  pix_grant;
    logic                  cpu_grant;
    logic                  ram_en;
    logic                  ram_we;
    logic [PAL_ADDR_W-1:0] ram_addr;
    logic [PAL_DATA_W-1:0] ram_rdata;
    logic [PAL_DATA_W-1:0] pix_entry;
    logic                  wr_p1;
    logic                  vld_p1;
    logic                  replay_p1;

    // Arbitration: renderer first unless the CPU has waited STARVE_MAX cycles.
    always_comb begin
        cpu_pend  = cpu_req && (state == C_IDLE);
        pix_grant = pix_req && (starve_cnt < STARVE_LIM);
        cpu_grant = cpu_pend && !pix_grant;
        ram_en    = pix_grant || cpu_grant;
        ram_we    = cpu_grant && cpu_we;
        ram_addr  = pix_grant ? pal_mirror(pix_idx) : pal_mirror(cpu_addr);
    end

    palette_ram u_ram (
        .clk   (Clk),
        .rst   (Reset),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (cpu_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            starve_cnt <= '0;
        end else if (!cpu_pend || cpu_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= C_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            C_IDLE:  if (cpu_grant) state_next = C_ACK;
            C_ACK:   state_next = C_IDLE;
            default: state_next = C_IDLE;
        endcase
    end

    // p1: access registered; remember whether the CPU slot was a write.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_p1 <= 1'b0;
        end else if (cpu_grant) begin
            wr_p1 <= cpu_we;
        end
    end

    always_comb begin
        cpu_ack   = (state == C_ACK);
        cpu_rdata = (cpu_ack && !wr_p1) ? ram_rdata : '0;
    end

    // p1: render request tracked alongside the RAM read; a lost slot replays.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_p1    <= 1'b0;
            replay_p1 <= 1'b0;
        end else begin
            vld_p1    <= pix_req;
            replay_p1 <= pix_req && !pix_grant;
        end
    end

`ifdef PAL_GRAYSCALE_EN
    assign pix_entry = grayscale ? (ram_rdata & GRAY_MASK) : ram_rdata;
`else
    logic gray_unused;
    assign gray_unused = grayscale;
    assign pix_entry   = ram_rdata;
`endif

    // p2: registered colour output towards palette_look_up.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pix_valid  <= 1'b0;
            color_code <= 8'h00;
        end else begin
            pix_valid <= vld_p1;
            if (vld_p1 && !replay_p1) begin
                color_code <= {2'b00, pix_entry};
            end
        end
    end

endmodule
